// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - pre/post trigger capture sequencer for a sample buffer
module capture_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int PRE_CNT   = 320,
  parameter int TOTAL_CNT = 640,
  parameter int AUTO_TO   = 4096
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              sample_valid,
  input  logic [11:0]       sample,
  input  logic [11:0]       TRIG,
  input  logic              slope,
  input  logic              run,
  input  logic              single,
  input  logic              auto_en,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              capture_done,
  output logic              auto_trig,
  output logic              busy
);

  localparam int POST_CNT = TOTAL_CNT - PRE_CNT;
  localparam int PRE_W    = $clog2(PRE_CNT + 1);
  localparam int POST_W   = $clog2(POST_CNT + 1);
  localparam int TO_W     = $clog2(AUTO_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ARMED, S_POST, S_HOLD
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ptr;
  logic [PRE_W-1:0]    pre_count;
  logic [POST_W-1:0]   post_count;
  logic [TO_W-1:0]     to_count;
  logic [11:0]         prev;
  logic                prev_ok;
  logic                single_pend;

  logic                accept;
  logic                trig_hit;
  logic                forced_hit;
  logic                keep_going;
  logic                real_trig;
  logic                timeout;
  logic [PRE_W-1:0]    pre_inc;
  logic [POST_W-1:0]   post_inc;
  logic [TO_W-1:0]     to_inc;

  assign pre_inc    = pre_count + PRE_W'(1);
  assign post_inc   = post_count + POST_W'(1);
  assign to_inc     = to_count + TO_W'(1);
  // A single-started capture keeps going even after run is released.
  assign keep_going = run | single_pend;
  assign real_trig  = prev_ok & (slope ? ((prev > TRIG) && (sample <= TRIG))
                                       : ((prev < TRIG) && (sample >= TRIG)));
  assign timeout    = auto_en && (to_inc == TO_W'(AUTO_TO));

  // State register; reset drops straight back to IDLE from anywhere.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode plus per-cycle sample acceptance and trigger qualification.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    trig_hit   = 1'b0;
    forced_hit = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (run || single) state_nx = S_PRE;
      end
      S_PRE: begin
        busy = 1'b1;
        if (!keep_going) begin
          state_nx = S_IDLE;
        end else if (sample_valid) begin
          accept = 1'b1;
          if (pre_inc == PRE_W'(PRE_CNT)) state_nx = S_ARMED;
        end
      end
      S_ARMED: begin
        busy = 1'b1;
        if (!keep_going) begin
          state_nx = S_IDLE;
        end else if (sample_valid) begin
          accept = 1'b1;
          if (real_trig) begin
            trig_hit = 1'b1;
            state_nx = S_POST;
          end else if (timeout) begin
            forced_hit = 1'b1;
            state_nx   = S_POST;
          end
        end
      end
      S_POST: begin
        busy = 1'b1;
        if (sample_valid) begin
          accept = 1'b1;
          if (post_inc == POST_W'(POST_CNT)) state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (frame_done) state_nx = run ? S_PRE : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Write port, counters, trigger history and capture results.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      start_addr   <= '0;
      capture_done <= 1'b0;
      auto_trig    <= 1'b0;
      ptr          <= '0;
      pre_count    <= '0;
      post_count   <= '0;
      to_count     <= '0;
      prev         <= '0;
      prev_ok      <= 1'b0;
      single_pend  <= 1'b0;
    end else begin
      wr_en        <= accept;
      capture_done <= 1'b0;
      if (accept) begin
        wr_addr <= ptr;
        wr_data <= sample;
        ptr     <= ptr + ADDR_W'(1);
        prev    <= sample;
        prev_ok <= 1'b1;
      end
      if (state != S_PRE && state_nx == S_PRE) begin
        pre_count  <= '0;
        post_count <= '0;
        prev_ok    <= 1'b0;
      end
      if (state == S_PRE && accept) pre_count <= pre_inc;
      if (state == S_PRE && state_nx == S_ARMED) to_count <= '0;
      if (state == S_ARMED && accept && auto_en) to_count <= to_inc;
      if (trig_hit || forced_hit) begin
        start_addr <= ptr - ADDR_W'(PRE_CNT);
        post_count <= POST_W'(1);
        auto_trig  <= forced_hit;
      end
      if (state == S_POST && accept) begin
        post_count <= post_inc;
        if (state_nx == S_HOLD) capture_done <= 1'b1;
      end
      if (state == S_IDLE && state_nx == S_PRE) single_pend <= single;
      else if (state_nx == S_IDLE || (state == S_HOLD && state_nx != S_HOLD)) single_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;
  localparam int ADDR_W    = 10;
  localparam int PRE_CNT   = 320;
  localparam int TOTAL_CNT = 640;
  localparam int AUTO_TO   = 4096;
  localparam int POST_CNT  = TOTAL_CNT - PRE_CNT;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RSTB = 1'b0;
  logic              sample_valid = 1'b0;
  logic [11:0]       sample = '0;
  logic [11:0]       TRIG = '0;
  logic              slope = 1'b0;
  logic              run = 1'b0;
  logic              single = 1'b0;
  logic              auto_en = 1'b0;
  logic              frame_done = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic [ADDR_W-1:0] start_addr;
  logic              capture_done;
  logic              auto_trig;
  logic              busy;

  capture_sequencer #(
    .ADDR_W(ADDR_W), .PRE_CNT(PRE_CNT), .TOTAL_CNT(TOTAL_CNT), .AUTO_TO(AUTO_TO)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .sample_valid(sample_valid), .sample(sample), .TRIG(TRIG),
    .slope(slope), .run(run), .single(single), .auto_en(auto_en), .frame_done(frame_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start_addr(start_addr),
    .capture_done(capture_done), .auto_trig(auto_trig), .busy(busy)
  );

  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int q_addr[$];
  int q_data[$];
  int done_cnt;
  int done_at;
  int ptr_m = 0;
  int last_addr = -1;
  bit wrap_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (wr_en) begin
      if (last_addr == DEPTH - 1 && wr_addr == 0) wrap_seen = 1'b1;
      last_addr = int'(wr_addr);
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
    end
    if (capture_done) begin
      done_cnt++;
      done_at = q_addr.size();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"}, wr_en, 0);
    check({name, "_wr_addr"}, wr_addr, 0);
    check({name, "_wr_data"}, wr_data, 0);
    check({name, "_start_addr"}, start_addr, 0);
    check({name, "_capture_done"}, capture_done, 0);
    check({name, "_auto_trig"}, auto_trig, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  function automatic int gen(input int mode, input int i);
    case (mode)
      0:       return (8 * i) % 4096;
      1:       return 4095 - ((8 * i) % 4096);
      2:       return 500;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  // variant: 0 plain, 1 drop run in POST, 2 reset mid-POST, 3 frame_done on last sample then rerun
  task automatic capture(input string name, input int mode, input int trig, input bit slp,
                         input bit aen, input bit use_single, input int variant);
    int smp[$];
    int k = -1;
    bit forced = 1'b0;
    int n;
    int ptr0 = ptr_m;
    int bad = 0;
    for (int i = 0; i < PRE_CNT + AUTO_TO + 8; i++) smp.push_back(gen(mode, i));
    for (int i = PRE_CNT; i < smp.size(); i++) begin
      bit rt;
      rt = slp ? (smp[i-1] > trig && smp[i] <= trig) : (smp[i-1] < trig && smp[i] >= trig);
      if (rt) begin k = i; break; end
      if (aen && (i - PRE_CNT + 1) == AUTO_TO) begin k = i; forced = 1'b1; break; end
    end
    n = (k < 0) ? smp.size() : k + POST_CNT;

    q_addr.delete();
    q_data.delete();
    done_cnt = 0;
    done_at  = -1;
    tick();
    TRIG = 12'(trig); slope = slp; auto_en = aen;
    if (use_single) begin run = 1'b0; single = 1'b1; end
    else run = 1'b1;
    tick();
    single = 1'b0;
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (n > 2000) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      repeat (gap) begin
        tick();
        sample_valid = 1'b0;
        frame_done = ($urandom_range(0, 9) == 0);
      end
      if (variant == 2 && k >= 0 && i == k + 5) begin
        tick();
        sample_valid = 1'b0;
        #2 RSTB = 1'b0;
        #1 check_reset_outputs({name, "_async"});
        sample_valid = 1'b1;
        sample = 12'd123;
        repeat (3) tick();
        check({name, "_wr_count"}, q_addr.size(), k + 5);
        RSTB = 1'b1; run = 1'b0; sample_valid = 1'b0; frame_done = 1'b0;
        tick();
        check({name, "_busy_after"}, busy, 0);
        ptr_m = 0;
        return;
      end
      tick();
      sample_valid = 1'b1;
      sample = 12'(smp[i]);
      frame_done = (variant == 3 && i == n - 1) ? 1'b1 : ($urandom_range(0, 9) == 0);
      if (variant == 1 && k >= 0 && i == k + 1) run = 1'b0;
    end

    if (k < 0) begin
      tick();
      sample_valid = 1'b0; frame_done = 1'b0;
      tick();
      check({name, "_no_done"}, done_cnt, 0);
      check({name, "_busy_armed"}, busy, 1);
      sample_valid = 1'b1; sample = 12'd900; run = 1'b0;
      tick();
      check({name, "_busy_abort"}, busy, 0);
      check({name, "_wr_en_abort"}, wr_en, 0);
      repeat (3) tick();
      sample_valid = 1'b0;
    end else begin
      tick();
      sample_valid = 1'b1; sample = 12'd77; frame_done = 1'b0;
      tick();
      tick();
      sample_valid = 1'b0;
      tick();
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_done_at"}, done_at, n);
      check({name, "_start_addr"}, start_addr, ((ptr0 + k - PRE_CNT) % DEPTH + DEPTH) % DEPTH);
      check({name, "_auto_trig"}, auto_trig, forced);
      check({name, "_busy_hold"}, busy, 0);
    end

    check({name, "_wr_count"}, q_addr.size(), n);
    for (int i = 0; i < q_addr.size() && i < n; i++)
      if (q_addr[i] != (ptr0 + i) % DEPTH || q_data[i] != smp[i]) bad++;
    check({name, "_wr_seq_bad"}, bad, 0);
    ptr_m = (ptr0 + n) % DEPTH;

    if (k >= 0 && variant == 3) begin
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      check({name, "_rerun_busy"}, busy, 1);
      run = 1'b0;
      tick();
      check({name, "_rerun_abort"}, busy, 0);
    end else if (k >= 0) begin
      run = 1'b0;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      sample_valid = 1'b1;
      repeat (4) tick();
      sample_valid = 1'b0;
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_idle_no_wr"}, q_addr.size(), n);
    end
  endtask

  initial begin
    #5 check_reset_outputs("reset");
    repeat (3) @(negedge CLK);
    RSTB = 1'b1;
    repeat (2) tick();
    check("idle_busy", busy, 0);

    capture("rise", 0, 2048, 1'b0, 1'b0, 1'b0, 3);
    capture("fall", 1, 1000, 1'b1, 1'b0, 1'b0, 1);
    capture("auto", 2, 2048, 1'b0, 1'b1, 1'b0, 0);
    capture("noauto", 2, 2048, 1'b0, 1'b0, 1'b0, 0);
    capture("single", 3, int'($urandom_range(200, 3800)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 0);
    for (int r = 0; r < 3; r++)
      capture("rand", 3, int'($urandom_range(200, 3800)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 0);
    check("wrap_seen", wrap_seen, 1);
    capture("rst", 0, 2048, 1'b0, 1'b0, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
